snooze_countdown: RTL

//   Loadable BCD down-counter (M:SS) for the alarm snooze/countdown path; the

---
 rtl/snooze_countdown.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/snooze_countdown.sv
// Loadable M:SS BCD down-counter for the snooze/countdown path.
// A TICK_DIV prescaler on tick_in paces the count; expire pulses once when RUN reaches 0:00.
module snooze_countdown #(
    parameter int TICK_DIV = 3,
    parameter int MAX_MIN  = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [2:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    output logic [3:0] min_o,
    output logic [2:0] tens_o,
    output logic [3:0] ones_o,
    output logic       running,
    output logic       expire,
    output logic [1:0] state_o
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MIN_CAP   = 4'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    min_q, min_d;
    logic [2:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          expire_q, expire_d;

    logic [3:0] lmin_c;
    logic [2:0] ltens_c;
    logic [3:0] lones_c;
    logic [3:0] dec_min;
    logic [2:0] dec_tens;
    logic [3:0] dec_ones;
    logic       dec_zero;
    logic       value_zero;

    always_comb begin
        lmin_c  = (load_min > MIN_CAP) ? MIN_CAP : load_min;
        ltens_c = (load_tens > 3'd5) ? 3'd5 : load_tens;
        lones_c = (load_ones > 4'd9) ? 4'd9 : load_ones;
    end

    // One-second borrow chain; minutes saturate at 0 since 0:00 is terminal.
    always_comb begin
        dec_min  = min_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (tens_q != 3'd0) begin
                dec_tens = tens_q - 3'd1;
            end else begin
                dec_tens = 3'd5;
                dec_min  = (min_q != 4'd0) ? min_q - 4'd1 : 4'd0;
            end
        end
        dec_zero   = (dec_min == 4'd0) && (dec_tens == 3'd0) && (dec_ones == 4'd0);
        value_zero = (min_q == 4'd0) && (tens_q == 3'd0) && (ones_q == 4'd0);
    end

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        presc_d  = presc_q;
        expire_d = 1'b0;
        if (cancel) begin
            state_d = S_IDLE;
            min_d   = 4'd0;
            tens_d  = 3'd0;
            ones_d  = 4'd0;
            presc_d = '0;
        end else if (load) begin
            state_d = S_LOADED;
            min_d   = lmin_c;
            tens_d  = ltens_c;
            ones_d  = lones_c;
            presc_d = '0;
        end else if (pause && (state_q == S_RUN || state_q == S_PAUSED)) begin
            state_d = S_PAUSED;
        end else if (start && state_q == S_LOADED) begin
            if (!value_zero) begin
                state_d = S_RUN;
                presc_d = '0;
            end
        end else if (start && state_q == S_PAUSED) begin
            state_d = S_RUN;
        end else if (tick_in && state_q == S_RUN) begin
            if (presc_q == PRESC_TOP) begin
                presc_d = '0;
                min_d   = dec_min;
                tens_d  = dec_tens;
                ones_d  = dec_ones;
                if (dec_zero) begin
                    state_d  = S_IDLE;
                    expire_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            min_q     <= 4'd0;
            tens_q    <= 3'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expire_q  <= expire_d;
        end
    end

    assign min_o   = min_q;
    assign tens_o  = tens_q;
    assign ones_o  = ones_q;
    assign running = running_q;
    assign expire  = expire_q;
    assign state_o = state_q;

endmodule
